// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes, default word size.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } uart_state_t;

  localparam int PAR_NONE  = 0;
  localparam int PAR_EVEN  = 1;
  localparam int PAR_ODD   = 2;
  localparam int DEF_NBITS = 8;

  // x is (XOR of data bits) ^ (received parity bit); maps it to an error flag.
  function automatic logic parity_error(input int mode, input logic x);
    case (mode)
      PAR_EVEN: return x;
      PAR_ODD:  return ~x;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level.
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic meta;

  // Double-register the line; both flops come out of reset high (line idle).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b1;
      dout <= 1'b1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable oversampling UART receiver with parity, stop-bit and break detection.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int NBITS       = DEF_NBITS,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = PAR_NONE,
  parameter int STOP_BITS   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_baud_rate,
  input  logic             i_rx,
  output logic             o_rx_done,
  output logic [NBITS-1:0] o_data,
  output logic             o_parity_err,
  output logic             o_frame_err,
  output logic             o_break
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(NBITS + 1);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(NBITS - 1);
  localparam logic [BW-1:0] S_LAST = BW'(STOP_BITS - 1);

  uart_state_t      state, state_nxt;
  logic             rx_s;
  logic [TW-1:0]    tick_cnt;
  logic [BW-1:0]    bit_cnt;     // data bit index, reused as stop bit index
  logic [NBITS-1:0] shreg;
  logic             par_bit;
  logic             frame_acc;   // some earlier stop sample was low
  logic             any_high;    // some data/parity/stop sample was high

  logic mid_hit, bit_hit, last_data, last_stop, frame_bad;

  rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (i_rx),
    .dout (rx_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Sample strobes derived from state and counters.
  always_comb begin
    mid_hit   = 1'b0;
    bit_hit   = 1'b0;
    last_data = 1'b0;
    last_stop = 1'b0;
    frame_bad = frame_acc | ~rx_s;
    if (state == ST_START)
      mid_hit = i_baud_rate && (tick_cnt == T_HALF);
    if (state == ST_DATA || state == ST_PARITY || state == ST_STOP)
      bit_hit = i_baud_rate && (tick_cnt == T_FULL);
    last_data = bit_hit && (state == ST_DATA) && (bit_cnt == B_LAST);
    last_stop = bit_hit && (state == ST_STOP) && (bit_cnt == S_LAST);
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (!rx_s) state_nxt = ST_START;
      ST_START:     if (mid_hit) state_nxt = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:      if (last_data) state_nxt = (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY:    if (bit_hit) state_nxt = ST_STOP;
      ST_STOP:      if (last_stop) state_nxt = frame_bad ? ST_WAIT_HIGH : ST_IDLE;
      ST_WAIT_HIGH: if (rx_s) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Counters, shift register, per-frame accumulators and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      par_bit      <= 1'b0;
      frame_acc    <= 1'b0;
      any_high     <= 1'b0;
      o_rx_done    <= 1'b0;
      o_data       <= '0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
    end else begin
      o_rx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          tick_cnt  <= '0;
          bit_cnt   <= '0;
          frame_acc <= 1'b0;
          any_high  <= 1'b0;
        end
        ST_START: begin
          if (i_baud_rate) tick_cnt <= mid_hit ? '0 : tick_cnt + TW'(1);
        end
        ST_DATA, ST_PARITY, ST_STOP: begin
          if (i_baud_rate) tick_cnt <= bit_hit ? '0 : tick_cnt + TW'(1);
          if (bit_hit) begin
            any_high <= any_high | rx_s;
            if (state == ST_DATA) begin
              shreg   <= {rx_s, shreg[NBITS-1:1]};
              bit_cnt <= last_data ? '0 : bit_cnt + BW'(1);
            end else if (state == ST_PARITY) begin
              par_bit <= rx_s;
            end else begin
              frame_acc <= frame_acc | ~rx_s;
              bit_cnt   <= bit_cnt + BW'(1);
            end
          end
          // Publish the whole frame result together on the last stop sample.
          if (last_stop) begin
            o_rx_done    <= 1'b1;
            o_data       <= shreg;
            o_parity_err <= parity_error(PARITY_MODE, (^shreg) ^ par_bit);
            o_frame_err  <= frame_bad;
            o_break      <= ~(any_high | rx_s);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench: three receivers (8N1, 8E1, 8N2) fed directed and random frames.
module tb_uart_rx_cfg;

  localparam int BITCLK = 64;  // 16 ticks per bit, one tick every 4 clk

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] tdiv = '0;
  logic [2:0] rx_line = '1;
  logic [2:0] done, perr, ferr, brk;
  logic [7:0] data [3];

  exp_t       q [3][$];
  logic [7:0] last_data [3];
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tdiv <= tdiv + 2'd1;
    tick <= (tdiv == 2'd3);
  end

  uart_rx_cfg u0 (
    .clk(clk), .rst(rst), .i_baud_rate(tick), .i_rx(rx_line[0]),
    .o_rx_done(done[0]), .o_data(data[0]), .o_parity_err(perr[0]),
    .o_frame_err(ferr[0]), .o_break(brk[0]));

  uart_rx_cfg #(.PARITY_MODE(1)) u1 (
    .clk(clk), .rst(rst), .i_baud_rate(tick), .i_rx(rx_line[1]),
    .o_rx_done(done[1]), .o_data(data[1]), .o_parity_err(perr[1]),
    .o_frame_err(ferr[1]), .o_break(brk[1]));

  uart_rx_cfg #(.STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .i_baud_rate(tick), .i_rx(rx_line[2]),
    .o_rx_done(done[2]), .o_data(data[2]), .o_parity_err(perr[2]),
    .o_frame_err(ferr[2]), .o_break(brk[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: frame outcome from the bits as sent on the line.
  function automatic exp_t model(input int k, input logic [7:0] d, input logic pbit,
                                 input logic [1:0] stops);
    exp_t e;
    logic has_par = (k == 1);
    logic [1:0] used = (k == 2) ? stops : {1'b1, stops[0]};
    e.data = d;
    e.perr = has_par ? ((^d) ^ pbit) : 1'b0;
    e.ferr = (used != 2'b11);
    e.brk  = (d == 8'h00) && (!has_par || !pbit) && ((k == 2) ? stops == 2'b00 : !stops[0]);
    return e;
  endfunction

  task automatic hold(input int k, input logic v, input int clks);
    rx_line[k] = v;
    repeat (clks) @(posedge clk);
  endtask

  // Send one frame on line k; extra_low keeps the line low afterwards (in bit times).
  task automatic send_frame(input int k, input logic [7:0] d, input logic pbit,
                            input logic [1:0] stops, input int extra_low);
    q[k].push_back(model(k, d, pbit, stops));
    last_data[k] = d;
    hold(k, 1'b0, BITCLK);
    for (int i = 0; i < 8; i++) hold(k, d[i], BITCLK);
    if (k == 1) hold(k, pbit, BITCLK);
    hold(k, stops[0], BITCLK);
    if (k == 2) hold(k, stops[1], BITCLK);
    if (extra_low > 0) hold(k, 1'b0, extra_low * BITCLK);
    hold(k, 1'b1, 2 * BITCLK);
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (done[k]) begin
        if (q[k].size() == 0) begin
          chk($sformatf("unexpected_done_dut%0d", k), 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q[k].pop_front();
          chk($sformatf("frame_dut%0d", k), {21'd0, data[k], perr[k], ferr[k], brk[k]},
              {21'd0, e});
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) last_data[k] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("reset_state_dut%0d", k), {20'd0, data[k], done[k], perr[k], ferr[k], brk[k]}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4 * BITCLK) @(posedge clk);

    // Basic frames on each configuration.
    send_frame(0, 8'hA5, 1'b0, 2'b11, 0);
    send_frame(1, 8'h3C, 1'b1, 2'b11, 0);   // wrong even parity
    send_frame(1, 8'h3C, 1'b0, 2'b11, 0);   // correct, flag clears
    // Short low glitch: no frame, output word unchanged.
    hold(0, 1'b0, 5 * 4);
    hold(0, 1'b1, 2 * BITCLK);
    chk("glitch_data_held", {24'd0, data[0]}, {24'd0, last_data[0]});
    send_frame(0, 8'h3E, 1'b0, 2'b11, 0);
    // Second stop low, line kept low 3 more bits, then a clean frame.
    send_frame(2, 8'h55, 1'b0, 2'b01, 3);
    send_frame(2, 8'h12, 1'b0, 2'b11, 0);
    // Line low for 12 bit times: one break frame.
    send_frame(0, 8'h00, 1'b0, 2'b00, 2);
    send_frame(0, 8'h5A, 1'b0, 2'b11, 0);

    // Reset in the middle of data bit 4 of 0xFF.
    hold(0, 1'b0, BITCLK);
    hold(0, 1'b1, 4 * BITCLK + BITCLK / 2);
    #2 rst = 1'b0;
    #1 chk("midframe_reset_outputs",
           {20'd0, data[0], done[0], perr[0], ferr[0], brk[0]}, 32'd0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    hold(0, 1'b1, 6 * BITCLK);
    send_frame(0, 8'h81, 1'b0, 2'b11, 0);

    // Random frames, mostly well formed.
    for (int n = 0; n < 30; n++) begin
      int         k;
      logic [7:0] d;
      logic       pb;
      logic [1:0] st;
      k  = $urandom_range(0, 2);
      d  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      pb = 1'($urandom);
      st = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      send_frame(k, d, pb, st, 0);
    end

    repeat (4 * BITCLK) @(posedge clk);
    for (int k = 0; k < 3; k++)
      chk($sformatf("missing_done_dut%0d", k), q[k].size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
